upc_checkout_ctrl: RTL and testbench
====================================

UPC_CHECKOUT_CTRL -- requirements
Module: upc_checkout_ctrl

Interface
REQ-001 Parameters SHALL be: COUNT_W, 4, width of item and theft counters; ALARM_CYCLES, 8, alarm hold time in cycles when timeout is compiled in.
REQ-002 Ports SHALL be: clk  in  1  system clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-004 scan  in  1  scanner trigger level (already synchronized), active-high.
REQ-005 upc  in  3  product code; upc[2:0] maps to board switches SW[9:7].
REQ-006 marked  in  1  item carries paid/security mark (SW[0]).
REQ-007 clear  in  1  operator acknowledge/clear, active-high level.
REQ-008 item_count  out  COUNT_W  accepted items since reset/clear.
REQ-009 theft_count  out  COUNT_W  stolen detections since reset/clear.
REQ-010 discontinued  out  1  last accepted item is discontinued.
REQ-011 alarm  out  1  stolen item detected, awaiting clear.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 FSM SHALL have states IDLE, CHECK, ACCEPT, ALARM.
REQ-014 scan_q SHALL register scan each cycle; scan edge = scan & ~scan_q.
REQ-015 IDLE: on scan edge with clear low, latch upc and marked, go to CHECK next cycle; otherwise stay.
REQ-016 CHECK (exactly one cycle) SHALL evaluate latched values: disc = upc[1] | (upc[0] & upc[2]); stolen = ~marked & ~upc[1] & (upc[0] | ~upc[2]).
REQ-017 CHECK with stolen=1 SHALL go to ALARM, increment theft_count, leave discontinued unchanged.
REQ-018 CHECK with stolen=0 SHALL go to ACCEPT, increment item_count, load discontinued <= disc.
REQ-019 Outputs SHALL update on the edge leaving CHECK: two cycles after the cycle a scan edge is sampled.
REQ-020 ACCEPT SHALL remain until scan is low, then return to IDLE; one item per scan press.
REQ-021 ALARM SHALL hold alarm=1 and remain until clear=1 (or timeout per REQ-029), then go to IDLE.
REQ-022 Counters SHALL saturate at 2^COUNT_W-1; no wrap-around.
REQ-023 clear=1 in IDLE or ALARM SHALL zero item_count, theft_count, discontinued and enter IDLE; clear in IDLE beats a simultaneous scan edge.
REQ-024 clear SHALL be ignored in CHECK and ACCEPT.
REQ-025 scan edges outside IDLE SHALL be ignored, not queued.
REQ-026 Unreachable state encodings SHALL return to IDLE next cycle.

Reset
REQ-027 reset SHALL asynchronously set state=IDLE, scan_q=0, latched upc/marked=0, item_count=0, theft_count=0, discontinued=0, alarm=0, busy=0.
REQ-028 Reset asserted mid-operation (CHECK, ACCEPT, ALARM) SHALL abort without counter update; operation resumes in IDLE the first edge after release, needing a fresh scan edge.

Configuration
REQ-029 Macro UPC_ALARM_TIMEOUT_EN: when defined, ALARM SHALL also exit to IDLE after ALARM_CYCLES cycles in ALARM (cycle counter cleared on ALARM entry), counters retained; clear still exits earlier. When undefined, ALARM exits only on clear or reset and no timeout counter exists.

Verification
REQ-030 reset; upc=3'b010, marked=0, scan 0->1 -> two cycles later item_count=1, discontinued=1, alarm=0, state ACCEPT.
REQ-031 upc=3'b000, marked=0, scan edge -> alarm=1, theft_count=1 two cycles later; hold clear low 20 cycles -> alarm stays 1 (macro undefined); clear=1 -> IDLE, counts=0.
REQ-032 Macro defined, ALARM_CYCLES=8: stolen scan -> alarm high exactly 8 cycles, then IDLE, theft_count=1 retained.
REQ-033 17 non-stolen scans (upc=3'b001, marked=1) with COUNT_W=4 -> item_count=15, discontinued=0.
REQ-034 scan held high 10 cycles -> item_count increments once; scan edge plus clear=1 same cycle in IDLE -> counts=0, no CHECK entry.
REQ-035 reset pulsed during CHECK -> all outputs 0 immediately, item_count unchanged (0) after release.

Source files
------------

// File: rtl/upc_checkout_ctrl.sv
// Self-checkout scanner controller: classifies each scanned UPC as accepted or stolen and keeps counts.
// Optional build macro UPC_ALARM_TIMEOUT_EN adds an automatic ALARM exit after ALARM_CYCLES cycles.
module upc_checkout_ctrl #(
  parameter int COUNT_W      = 4,
  parameter int ALARM_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan,
  input  logic [2:0]         upc,
  input  logic               marked,
  input  logic               clear,
  output logic [COUNT_W-1:0] item_count,
  output logic [COUNT_W-1:0] theft_count,
  output logic               discontinued,
  output logic               alarm,
  output logic               busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_ACCEPT = 2'd2;
  localparam logic [1:0] S_ALARM  = 2'd3;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [1:0]         r_state;
  logic               r_scan_q;
  logic [2:0]         r_upc;
  logic               r_marked;
  logic [COUNT_W-1:0] r_item_cnt;
  logic [COUNT_W-1:0] r_theft_cnt;
  logic               r_disc;

  logic w_scan_edge;
  logic w_disc;
  logic w_stolen;
  logic w_alarm_timeout;

  assign w_scan_edge = scan & ~r_scan_q;
  assign w_disc      = r_upc[1] | (r_upc[0] & r_upc[2]);
  assign w_stolen    = ~r_marked & ~r_upc[1] & (r_upc[0] | ~r_upc[2]);

`ifdef UPC_ALARM_TIMEOUT_EN
  localparam int ACW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

  logic [ACW-1:0] r_alarm_cnt;

  // Counter restarts while in CHECK so every ALARM visit gets a full hold time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alarm_cnt <= '0;
    end else if (r_state == S_ALARM) begin
      r_alarm_cnt <= r_alarm_cnt + 1'b1;
    end else begin
      r_alarm_cnt <= '0;
    end
  end

  assign w_alarm_timeout = (r_alarm_cnt == ACW'(ALARM_CYCLES - 1));
`else
  // No timeout hardware: the ALARM state only leaves on clear or reset.
  assign w_alarm_timeout = (ALARM_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_scan_q    <= 1'b0;
      r_upc       <= 3'b000;
      r_marked    <= 1'b0;
      r_item_cnt  <= '0;
      r_theft_cnt <= '0;
      r_disc      <= 1'b0;
    end else begin
      r_scan_q <= scan;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_item_cnt  <= '0;
            r_theft_cnt <= '0;
            r_disc      <= 1'b0;
          end else if (w_scan_edge) begin
            r_upc    <= upc;
            r_marked <= marked;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_stolen) begin
            r_state <= S_ALARM;
            if (r_theft_cnt != CNT_MAX) r_theft_cnt <= r_theft_cnt + 1'b1;
          end else begin
            r_state <= S_ACCEPT;
            r_disc  <= w_disc;
            if (r_item_cnt != CNT_MAX) r_item_cnt <= r_item_cnt + 1'b1;
          end
        end
        S_ACCEPT: begin
          if (!scan) r_state <= S_IDLE;
        end
        S_ALARM: begin
          if (clear) begin
            r_item_cnt  <= '0;
            r_theft_cnt <= '0;
            r_disc      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_alarm_timeout) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign item_count   = r_item_cnt;
  assign theft_count  = r_theft_cnt;
  assign discontinued = r_disc;
  assign alarm        = (r_state == S_ALARM);
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_upc_checkout_ctrl.sv
// Bench for upc_checkout_ctrl: vector table, directed corner sequences and a random run against a code-set model.
module tb_upc_checkout_ctrl;
  localparam int COUNT_W      = 4;
  localparam int ALARM_CYCLES = 8;
  localparam int MAXC         = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               scan;
  logic [2:0]         upc;
  logic               marked;
  logic               clear;
  logic [COUNT_W-1:0] item_count;
  logic [COUNT_W-1:0] theft_count;
  logic               discontinued;
  logic               alarm;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  upc_checkout_ctrl #(.COUNT_W(COUNT_W), .ALARM_CYCLES(ALARM_CYCLES)) dut (
    .clk(clk), .reset(reset), .scan(scan), .upc(upc), .marked(marked), .clear(clear),
    .item_count(item_count), .theft_count(theft_count), .discontinued(discontinued),
    .alarm(alarm), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] upc;
    logic       marked;
    logic       exp_alarm;
    logic       exp_disc;
  } vec_t;

  vec_t vecs [12];
  bit   stolen_codes [8];
  bit   disc_codes   [8];

  int m_item, m_theft, m_disc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Rising scan, then two edges: CHECK and the decision edge.
  task automatic press(input logic [2:0] u, input logic mk);
    upc    = u;
    marked = mk;
    scan   = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int hi_cnt;
    // Codes that trip the alarm when unmarked, and codes reported as discontinued.
    stolen_codes = '{1, 1, 0, 0, 0, 1, 0, 0};
    disc_codes   = '{0, 0, 1, 1, 0, 1, 1, 1};

    vecs[0]  = '{3'b000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'b001, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'b010, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{3'b011, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{3'b100, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b101, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3'b110, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{3'b111, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{3'b000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'b001, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b101, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{3'b100, 1'b1, 1'b0, 0};

    reset = 1'b1; scan = 1'b0; upc = 3'b000; marked = 1'b0; clear = 1'b0;
    #2;
    chk("rst_item", int'(item_count), 0);
    chk("rst_theft", int'(theft_count), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_disc", int'(discontinued), 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Table: each vector starts from cleared counts.
    for (int i = 0; i < 12; i++) begin
      do_clear();
      press(vecs[i].upc, vecs[i].marked);
      $display("[TB] vec %0d upc=%b marked=%b alarm=%0d disc=%0d items=%0d thefts=%0d",
               i, vecs[i].upc, vecs[i].marked, alarm, discontinued, item_count, theft_count);
      chk("vec_alarm", int'(alarm), int'(vecs[i].exp_alarm));
      chk("vec_disc", int'(discontinued), int'(vecs[i].exp_disc));
      chk("vec_items", int'(item_count), vecs[i].exp_alarm ? 0 : 1);
      chk("vec_thefts", int'(theft_count), vecs[i].exp_alarm ? 1 : 0);
      scan  = 1'b0;
      clear = vecs[i].exp_alarm;
      tick();
      clear = 1'b0;
      chk("vec_idle", int'(busy), 0);
    end

    // Alarm hold: stays up without clear, or times out when the timeout is built in.
    do_clear();
    press(3'b000, 1'b0);
    chk("alarm_theft", int'(theft_count), 1);
    hi_cnt = 0;
    for (int c = 0; c < 21; c++) begin
      if (alarm) hi_cnt++;
      if (c < 20) tick();
    end
`ifdef UPC_ALARM_TIMEOUT_EN
    chk("alarm_timeout_len", hi_cnt, ALARM_CYCLES);
    chk("alarm_timeout_theft", int'(theft_count), 1);
    chk("alarm_timeout_busy", int'(busy), 0);
`else
    chk("alarm_hold_len", hi_cnt, 21);
`endif
    $display("[TB] alarm hold: high for %0d samples", hi_cnt);
    scan = 1'b0;
    do_clear();
    chk("alarm_clr_theft", int'(theft_count), 0);
    chk("alarm_clr_busy", int'(busy), 0);

    // Saturation after 17 good scans.
    do_clear();
    for (int k = 0; k < 17; k++) begin
      press(3'b001, 1'b1);
      scan = 1'b0;
      tick();
    end
    $display("[TB] 17 scans: items=%0d disc=%0d", item_count, discontinued);
    chk("sat_items", int'(item_count), MAXC);
    chk("sat_disc", int'(discontinued), 0);

    // Long press counts once; clear beats a simultaneous scan edge.
    do_clear();
    upc = 3'b100; marked = 1'b1; scan = 1'b1;
    repeat (10) tick();
    scan = 1'b0;
    tick();
    chk("hold_items", int'(item_count), 1);
    clear = 1'b1; scan = 1'b1;
    tick();
    chk("clr_scan_items", int'(item_count), 0);
    chk("clr_scan_busy", int'(busy), 0);
    tick();
    chk("clr_scan_busy2", int'(busy), 0);
    clear = 1'b0; scan = 1'b0;
    tick();
    $display("[TB] hold/clear sequence done items=%0d", item_count);

    // Reset during CHECK aborts the transaction.
    upc = 3'b010; marked = 1'b1; scan = 1'b1;
    tick();
    chk("chk_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_chk_busy", int'(busy), 0);
    chk("rst_chk_items", int'(item_count), 0);
    chk("rst_chk_alarm", int'(alarm), 0);
    scan = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("rst_rel_items", int'(item_count), 0);
    chk("rst_rel_busy", int'(busy), 0);

    // Reset during ALARM drops the alarm at once.
    press(3'b001, 1'b0);
    chk("pre_rst_alarm", int'(alarm), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_alarm_now", int'(alarm), 0);
    chk("rst_alarm_theft", int'(theft_count), 0);
    scan = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    $display("[TB] reset-abort sequences done");

    // Random transactions against the code-set model.
    m_item = 0; m_theft = 0; m_disc = 0;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(7) == 0) begin
        do_clear();
        m_item = 0; m_theft = 0; m_disc = 0;
        chk("rnd_clr_items", int'(item_count), m_item);
        chk("rnd_clr_thefts", int'(theft_count), m_theft);
        $display("[TB] rnd %0d clear", t);
      end else begin
        logic [2:0] u;
        logic       mk;
        bit         stl;
        int         hold;
        u   = 3'($urandom_range(7));
        mk  = 1'($urandom_range(1));
        stl = !mk && stolen_codes[u];
        press(u, mk);
        if (stl) begin
          if (m_theft < MAXC) m_theft++;
        end else begin
          if (m_item < MAXC) m_item++;
          m_disc = int'(disc_codes[u]);
        end
        $display("[TB] rnd %0d upc=%b marked=%b alarm=%0d items=%0d thefts=%0d disc=%0d",
                 t, u, mk, alarm, item_count, theft_count, discontinued);
        chk("rnd_alarm", int'(alarm), int'(stl));
        chk("rnd_items", int'(item_count), m_item);
        chk("rnd_thefts", int'(theft_count), m_theft);
        chk("rnd_disc", int'(discontinued), m_disc);
        hold = int'($urandom_range(3));
        for (int h = 0; h < hold; h++) begin
          if (!stl) clear = 1'($urandom_range(1));
          tick();
        end
        scan  = 1'b0;
        clear = stl;
        tick();
        clear = 1'b0;
        if (stl) begin
          m_item = 0; m_theft = 0; m_disc = 0;
        end
        chk("rnd_items_after", int'(item_count), m_item);
        chk("rnd_busy_after", int'(busy), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
